pe_dmux_route: RTL and testbench
================================

# pe_dmux_route

Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking, used in the PE datapath to steer one accumulator/operand stream to one of N downstream lanes, or to all lanes at once. Generalises the plain two-way combinational demux:

- configurable width and channel count
- a one-entry output register per lane
- a broadcast mode
- out-of-range select detection
- a saturating transfer counter

## Interface

Parameters:
- W, 24, data width in bits
- N, 4, number of output lanes (2..16)
- SELW, $clog2(N), select width
- CNTW, 16, width of accepted-transfer counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  input word can be accepted this cycle
- in_data  in  W  input word
- in_sel  in  SELW  target lane index
- in_bcast  in  1  1 = write to all N lanes; in_sel ignored
- out_valid  out  N  per-lane valid
- out_ready  in  N  per-lane ready from consumer
- out_data  out  N*W  lane k at bits [k*W +: W]
- err_sel  out  1  sticky: an in_sel >= N was accepted
- xfer_cnt  out  CNTW  accepted input words, saturating

## Operation

- Each lane k has a one-entry holding register, buf_k, with a full flag that drives out_valid[k].
- Target set T:
  - in_bcast=1: all lanes.
  - in_bcast=0 and in_sel<N: lane in_sel only.
  - in_bcast=0 and in_sel>=N: empty set.
- Lane k is free when !full_k or out_ready[k].
- in_ready = AND over k in T of free_k.
  - Empty T: in_ready=1.
  - in_ready must not depend on in_valid.
- Accept = in_valid && in_ready. On accept, every lane in T loads in_data and sets full; lanes outside T are unchanged.
- Accept with empty T: word is discarded, err_sel sets and stays set until rst, xfer_cnt still increments.
- Lane drain: out_valid[k] && out_ready[k] clears full_k, unless the same cycle's accept reloads it. In that case full_k stays 1 with the new data.
- out_data lane k equals buf_k when full_k, else all zeros. A lane never presents stale data.
- xfer_cnt increments by 1 per accept, broadcast counts once, and saturates at 2^CNTW-1.
- Lanes drain independently. A broadcast waits until every lane is free; there is no partial broadcast.
- rst mid-operation discards all held words, regardless of out_ready.

## Timing

- Reset values:
  - in_ready=1 (all lanes empty)
  - out_valid=0
  - out_data=0
  - err_sel=0
  - xfer_cnt=0
- Latency: a word accepted at edge t is on out_data/out_valid after edge t, i.e. 1 cycle.
- Throughput: 1 word/cycle to a continuously ready lane, with no bubble on back-to-back same-lane writes (simultaneous drain+load).
- Back-pressure: target full and out_ready=0 gives in_ready=0. in_data/in_sel/in_bcast must then be held by the producer while in_valid=1.
- out_valid[k] stays asserted and out_data lane k stays stable until the handshake completes.
- rst asserted with in_valid=1: no accept that cycle; counter and flags reset.

## Test plan

- Reset, N=4, W=24: after rst, out_valid=4'b0000, out_data=0, in_ready=1, xfer_cnt=0, err_sel=0.
- Single steer: in_data=24'h123456, in_sel=2, out_ready=4'b1111.
  - Next cycle out_valid=4'b0100, lane 2 = 24'h123456, lanes 0/1/3 = 0.
  - Following cycle out_valid=0.
  - xfer_cnt=1.
- Back-pressure: out_ready[1]=0, send 24'hAAAAAA then 24'hBBBBBB to lane 1.
  - First is held.
  - in_ready=0 for the second while the target is lane 1.
  - A word to lane 0 is accepted meanwhile.
  - Raise out_ready[1]: AAAAAA drains, then BBBBBB appears with no bubble.
- Broadcast: in_bcast=1, in_data=24'h00FF00, with lane 3 full and out_ready[3]=0.
  - in_ready=0.
  - Release lane 3: all four lanes show 24'h00FF00 together.
  - xfer_cnt +1.
- Bad select: N=3, SELW=2, in_sel=3, in_valid=1.
  - Accepted (in_ready=1).
  - No out_valid.
  - err_sel=1 and stays 1 through later valid traffic until rst.
- Saturation/reset: CNTW=4, 20 accepts leaves xfer_cnt=15. Mid-stream rst with lanes full gives all outputs back to reset values next cycle.

Source files
------------

// File: rtl/pe_dmux_route.sv
// Registered 1-to-N demultiplexer: steers one valid/ready stream into N one-entry
// lane buffers, or broadcasts to all lanes, with bad-select flag and transfer count.
module pe_dmux_route #(
  parameter int W    = 24,
  parameter int N    = 4,
  parameter int SELW = $clog2(N),
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [SELW-1:0]   in_sel,
  input  logic              in_bcast,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic [N*W-1:0]    out_data,
  output logic              err_sel,
  output logic [CNTW-1:0]   xfer_cnt
);

  // Handshake: a word moves on any edge where valid && ready are both high.
  // in_ready is a function of lane state, in_sel and in_bcast only, never of
  // in_valid; a lane drain and a reload of the same lane may share one edge.

  logic [N-1:0]    tgt;
  logic [N-1:0]    free;
  logic [N-1:0]    full;
  logic [W-1:0]    lane_buf [N];
  logic            sel_ok;
  logic            accept;
  logic            err_q;
  logic [CNTW-1:0] cnt_q;

  always_comb begin
    sel_ok = (32'(in_sel) < N);
    tgt    = '0;
    if (in_bcast) begin
      tgt = '1;
    end else if (sel_ok) begin
      tgt = N'(1) << in_sel;
    end
  end

  // Out-of-range select gives an empty target set, so it is always accepted.
  assign free     = ~full | out_ready;
  assign in_ready = &(free | ~tgt);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (accept && tgt[k]) begin
          full[k] <= 1'b1;
        end else if (out_ready[k]) begin
          full[k] <= 1'b0;
        end
      end
      if (accept && (tgt == '0)) begin
        err_q <= 1'b1;
      end
      if (accept && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Buffer contents need no reset: they are masked by the full flags.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (accept && tgt[k]) begin
        lane_buf[k] <= in_data;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign out_data[g*W +: W] = full[g] ? lane_buf[g] : '0;
  end

  assign out_valid = full;
  assign err_sel   = err_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_pe_dmux_route.sv
// Bench for pe_dmux_route: a 4-lane instance (a) and a 3-lane, 4-bit-counter
// instance (b), both checked every cycle against a lane-slot model plus literals.
module tb_pe_dmux_route;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a: N=4, CNTW=16
  logic        a_valid, a_ready, a_bcast, a_err;
  logic [23:0] a_data;
  logic [1:0]  a_sel;
  logic [3:0]  a_ovalid, a_oready;
  logic [95:0] a_odata;
  logic [15:0] a_cnt;

  // instance b: N=3, CNTW=4
  logic        b_valid, b_ready, b_bcast, b_err;
  logic [23:0] b_data;
  logic [1:0]  b_sel;
  logic [2:0]  b_ovalid, b_oready;
  logic [71:0] b_odata;
  logic [3:0]  b_cnt;

  pe_dmux_route #(.W(24), .N(4), .CNTW(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_sel(a_sel), .in_bcast(a_bcast),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata),
    .err_sel(a_err), .xfer_cnt(a_cnt)
  );

  pe_dmux_route #(.W(24), .N(3), .CNTW(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata),
    .err_sel(b_err), .xfer_cnt(b_cnt)
  );

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: each lane is a slot that is empty or holds one word
  logic [23:0] m_data [2][4];
  bit          m_full [2][4];
  bit          m_err  [2];
  int          m_cnt  [2];

  function automatic int lanes(int i);
    return (i == 0) ? 4 : 3;
  endfunction
  function automatic int cnt_max(int i);
    return (i == 0) ? 65535 : 15;
  endfunction
  function automatic bit in_v(int i);
    return (i == 0) ? a_valid : b_valid;
  endfunction
  function automatic bit in_bc(int i);
    return (i == 0) ? a_bcast : b_bcast;
  endfunction
  function automatic int in_s(int i);
    return (i == 0) ? int'(a_sel) : int'(b_sel);
  endfunction
  function automatic logic [23:0] in_d(int i);
    return (i == 0) ? a_data : b_data;
  endfunction
  function automatic bit oready(int i, int k);
    return (i == 0) ? a_oready[k] : b_oready[k];
  endfunction
  function automatic bit targeted(int i, int k);
    if (in_bc(i)) return 1'b1;
    return in_s(i) == k;
  endfunction
  // A word can go when no targeted slot is occupied by an unconsumed word.
  function automatic bit m_ready(int i);
    for (int k = 0; k < lanes(i); k++)
      if (targeted(i, k) && m_full[i][k] && !oready(i, k)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit acc;
      if (rst) begin
        for (int k = 0; k < 4; k++) m_full[i][k] = 1'b0;
        m_err[i] = 1'b0;
        m_cnt[i] = 0;
      end else begin
        acc = in_v(i) && m_ready(i);
        for (int k = 0; k < lanes(i); k++) begin
          if (acc && targeted(i, k)) begin
            m_full[i][k] = 1'b1;
            m_data[i][k] = in_d(i);
          end else if (oready(i, k)) begin
            m_full[i][k] = 1'b0;
          end
        end
        if (acc) begin
          if (!in_bc(i) && in_s(i) >= lanes(i)) m_err[i] = 1'b1;
          if (m_cnt[i] < cnt_max(i)) m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_ready", 96'(a_ready), 96'(m_ready(0)));
      chk("a_err",   96'(a_err),   96'(m_err[0]));
      chk("a_cnt",   96'(a_cnt),   96'(m_cnt[0]));
      for (int k = 0; k < 4; k++) begin
        chk("a_valid", 96'(a_ovalid[k]), 96'(m_full[0][k]));
        chk("a_data",  96'(a_odata[k*24 +: 24]), 96'(m_full[0][k] ? m_data[0][k] : 24'h0));
      end
      chk("b_ready", 96'(b_ready), 96'(m_ready(1)));
      chk("b_err",   96'(b_err),   96'(m_err[1]));
      chk("b_cnt",   96'(b_cnt),   96'(m_cnt[1]));
      for (int k = 0; k < 3; k++) begin
        chk("b_valid", 96'(b_ovalid[k]), 96'(m_full[1][k]));
        chk("b_data",  96'(b_odata[k*24 +: 24]), 96'(m_full[1][k] ? m_data[1][k] : 24'h0));
      end
    end
  end

  // ---------------- driver
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic a_send(input logic [23:0] d, input logic [1:0] s, input logic bc);
    a_valid = 1'b1; a_data = d; a_sel = s; a_bcast = bc;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_data = 0; a_sel = 0; a_bcast = 0; a_oready = 0;
    b_valid = 0; b_data = 0; b_sel = 0; b_bcast = 0; b_oready = 0;
    cyc(); cyc();
    rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_ready", 96'(a_ready), 96'd1);
    chk("rst_valid", 96'(a_ovalid), 96'd0);
    chk("rst_data",  a_odata, 96'd0);
    chk("rst_cnt",   96'(a_cnt), 96'd0);
    chk("rst_err",   96'(a_err), 96'd0);

    // single steer to lane 2
    a_oready = 4'b1111;
    a_send(24'h123456, 2'd2, 1'b0);
    cyc();
    a_valid = 1'b0;
    #1;
    chk("steer_valid", 96'(a_ovalid), 96'(4'b0100));
    chk("steer_data",  a_odata, {24'h0, 24'h123456, 24'h0, 24'h0});
    chk("steer_cnt",   96'(a_cnt), 96'd1);
    cyc();
    chk("steer_drain", 96'(a_ovalid), 96'd0);

    // back-pressure on lane 1
    a_oready = 4'b1101;
    a_send(24'hAAAAAA, 2'd1, 1'b0);
    cyc();
    a_send(24'hBBBBBB, 2'd1, 1'b0);
    #1;
    chk("bp_ready_lo", 96'(a_ready), 96'd0);
    cyc();
    a_send(24'h111111, 2'd0, 1'b0);
    #1;
    chk("bp_lane0_ready", 96'(a_ready), 96'd1);
    cyc();
    a_send(24'hBBBBBB, 2'd1, 1'b0);
    #1;
    chk("bp_hold_data", 96'(a_odata[47:24]), 96'(24'hAAAAAA));
    chk("bp_ready_lo2", 96'(a_ready), 96'd0);
    a_oready = 4'b1111;
    #1;
    chk("bp_ready_hi", 96'(a_ready), 96'd1);
    cyc();
    a_valid = 1'b0;
    #1;
    chk("bp_nobubble_v", 96'(a_ovalid[1]), 96'd1);
    chk("bp_nobubble_d", 96'(a_odata[47:24]), 96'(24'hBBBBBB));
    chk("bp_cnt", 96'(a_cnt), 96'd4);
    cyc();

    // broadcast blocked by full lane 3
    a_oready = 4'b0111;
    a_send(24'h333333, 2'd3, 1'b0);
    cyc();
    a_send(24'h00FF00, 2'd0, 1'b1);
    #1;
    chk("bc_ready_lo", 96'(a_ready), 96'd0);
    cyc();
    chk("bc_no_partial", 96'(a_ovalid), 96'(4'b1000));
    chk("bc_lane3_hold", 96'(a_odata[95:72]), 96'(24'h333333));
    a_oready = 4'b1111;
    #1;
    chk("bc_ready_hi", 96'(a_ready), 96'd1);
    cyc();
    a_valid = 1'b0; a_bcast = 1'b0;
    #1;
    chk("bc_valid", 96'(a_ovalid), 96'(4'b1111));
    chk("bc_data",  a_odata, {24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h00FF00});
    chk("bc_cnt",   96'(a_cnt), 96'd6);
    cyc();

    // bad select on the 3-lane instance
    b_oready = 3'b111;
    b_valid = 1'b1; b_sel = 2'd3; b_data = 24'hDEAD00;
    #1;
    chk("bad_ready", 96'(b_ready), 96'd1);
    cyc();
    b_sel = 2'd0; b_data = 24'h000001;
    #1;
    chk("bad_novalid", 96'(b_ovalid), 96'd0);
    chk("bad_err", 96'(b_err), 96'd1);
    chk("bad_cnt", 96'(b_cnt), 96'd1);
    cyc();
    b_valid = 1'b0;
    #1;
    chk("bad_err_sticky", 96'(b_err), 96'd1);
    chk("bad_then_good", 96'(b_ovalid), 96'(3'b001));
    cyc();

    // counter saturation: 20 more accepts on a 4-bit counter
    b_valid = 1'b1; b_sel = 2'd1;
    for (int i = 0; i < 20; i++) begin
      b_data = 24'(i + 16);
      cyc();
    end
    b_valid = 1'b0;
    #1;
    chk("sat_cnt", 96'(b_cnt), 96'd15);
    chk("sat_err", 96'(b_err), 96'd1);
    cyc();

    // mixed traffic on both instances
    for (int i = 0; i < 200; i++) begin
      a_valid  = 1'($urandom_range(0, 1));
      a_data   = 24'($urandom_range(0, 24'hFFFFFF));
      a_sel    = 2'($urandom_range(0, 3));
      a_bcast  = ($urandom_range(0, 7) == 0);
      a_oready = 4'($urandom_range(0, 15));
      b_valid  = 1'($urandom_range(0, 1));
      b_data   = 24'($urandom_range(0, 24'hFFFFFF));
      b_sel    = 2'($urandom_range(0, 3));
      b_bcast  = ($urandom_range(0, 7) == 0);
      b_oready = 3'($urandom_range(0, 7));
      cyc();
    end

    // mid-stream reset with every lane full and valid still high
    a_oready = 4'b0000; b_oready = 3'b000;
    a_send(24'h777777, 2'd0, 1'b1);
    b_valid = 1'b1; b_bcast = 1'b1; b_data = 24'h555555;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_bcast = 1'b0; b_bcast = 1'b0;
    #1;
    chk("mrst_a_valid", 96'(a_ovalid), 96'd0);
    chk("mrst_a_data",  a_odata, 96'd0);
    chk("mrst_a_ready", 96'(a_ready), 96'd1);
    chk("mrst_a_cnt",   96'(a_cnt), 96'd0);
    chk("mrst_b_valid", 96'(b_ovalid), 96'd0);
    chk("mrst_b_err",   96'(b_err), 96'd0);
    chk("mrst_b_cnt",   96'(b_cnt), 96'd0);
    cyc(); cyc();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
